// File: rtl/dot_pkg.sv
// Shared definitions for the dot-matrix scan controller: board geometry,
// cell-write opcodes, scan FSM states and the row-select decode.
package dot_pkg;

    localparam int ROWS = 8;
    localparam int COLS = 16;

    localparam logic [1:0] OP_CLR_POS  = 2'b00;
    localparam logic [1:0] OP_SET_POS  = 2'b01;
    localparam logic [1:0] OP_SET_MARK = 2'b10;
    localparam logic [1:0] OP_CLR_MARK = 2'b11;

    typedef enum logic [1:0] {
        SCAN_BLANK = 2'd0,
        SCAN_ON    = 2'd1,
        CLEAR      = 2'd2
    } scan_state_t;

    // Active-low row select: row 0 drives bit 7 low, row 7 drives bit 0 low.
    function automatic logic [7:0] row_select(input logic [2:0] row);
        return ~(8'h80 >> row);
    endfunction

endpackage

// File: rtl/dot_scan_ctrl_tick_gen.sv
// Free-running modulo-DIV counter with a wrap pulse on its last count.
// A synchronous clear holds the counter at zero.
module tick_gen #(
    parameter int DIV = 2500,
    parameter int W   = (DIV > 1) ? $clog2(DIV) : 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         wrap
);

    assign wrap = (count == W'(DIV - 1));

    // Count 0..DIV-1 and roll over; clear forces the count back to zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (wrap) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/dot_scan_ctrl.sv
// Dot-matrix scan controller: 8x16 position/mark buffers written through a
// valid/ready port, scanned one row per tick period with a blanking gap,
// mark cells blinking, and an 8-cycle whole-board clear.
module dot_scan_ctrl
    import dot_pkg::*;
#(
    parameter int TICK_DIV  = 2500,
    parameter int BLANK     = 8,
    parameter int BLINK_DIV = 12500000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [2:0]  wr_row,
    input  logic [3:0]  wr_col,
    input  logic [1:0]  wr_op,
    input  logic        clr_all,
    output logic [7:0]  dotR,
    output logic [15:0] dotC,
    output logic        frame_start,
    output logic        busy
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    scan_state_t     state_r;
    logic [2:0]      row_r;
    logic [2:0]      clr_row_r;
    logic            blink_r;
    logic [COLS-1:0] pos_r  [ROWS];
    logic [COLS-1:0] mark_r [ROWS];

    logic [TW-1:0]   tick_s;
    logic            tick_wrap_s;
    logic            tick_clr_s;
    logic [BW-1:0]   blink_count_unused;
    logic            blink_wrap_s;
    logic            wr_fire_s;

    // The row timer is held at zero while a clear is requested or running,
    // so scanning always restarts at tick 0 of row 0.
    assign tick_clr_s = clr_all || (state_r == CLEAR);
    assign wr_ready   = !reset && (state_r != CLEAR) && !clr_all;
    assign wr_fire_s  = wr_valid && wr_ready;

    tick_gen #(.DIV(TICK_DIV), .W(TW)) u_row_tick (
        .clock (clock),
        .reset (reset),
        .clr   (tick_clr_s),
        .count (tick_s),
        .wrap  (tick_wrap_s)
    );

    tick_gen #(.DIV(BLINK_DIV), .W(BW)) u_blink_tick (
        .clock (clock),
        .reset (reset),
        .clr   (1'b0),
        .count (blink_count_unused),
        .wrap  (blink_wrap_s)
    );

    // Blink phase toggles every blink period regardless of scan state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            blink_r <= 1'b0;
        end else if (blink_wrap_s) begin
            blink_r <= ~blink_r;
        end else begin
            blink_r <= blink_r;
        end
    end

    // Row counter advances on each row-period wrap, 7 rolls over to 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            row_r <= 3'd0;
        end else if (tick_clr_s) begin
            row_r <= 3'd0;
        end else if (tick_wrap_s) begin
            row_r <= row_r + 3'd1;
        end else begin
            row_r <= row_r;
        end
    end

    // Buffer storage: clear wipes one row per cycle, otherwise apply writes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < ROWS; r++) begin
                pos_r[r]  <= '0;
                mark_r[r] <= '0;
            end
        end else if ((state_r == CLEAR) && !clr_all) begin
            pos_r[clr_row_r]  <= '0;
            mark_r[clr_row_r] <= '0;
        end else if (wr_fire_s) begin
            case (wr_op)
                OP_CLR_POS: begin
                    pos_r[wr_row][wr_col] <= 1'b0;
                end
                OP_SET_POS: begin
                    pos_r[wr_row][wr_col]  <= 1'b1;
                    mark_r[wr_row][wr_col] <= 1'b0;
                end
                OP_SET_MARK: begin
                    // A mark never overlays a cell that already holds a position.
                    if (!pos_r[wr_row][wr_col]) begin
                        mark_r[wr_row][wr_col] <= 1'b1;
                    end else begin
                        mark_r[wr_row][wr_col] <= mark_r[wr_row][wr_col];
                    end
                end
                OP_CLR_MARK: begin
                    mark_r[wr_row][wr_col] <= 1'b0;
                end
                default: begin
                    pos_r[wr_row][wr_col] <= pos_r[wr_row][wr_col];
                end
            endcase
        end
    end

    // Scan FSM plus registered display outputs derived from the current state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= SCAN_BLANK;
            clr_row_r   <= 3'd0;
            dotR        <= 8'hFF;
            dotC        <= 16'h0000;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state_r)
                SCAN_ON: begin
                    dotR <= row_select(row_r);
                    dotC <= pos_r[row_r] | (blink_r ? mark_r[row_r] : 16'h0000);
                end
                default: begin
                    dotR <= 8'hFF;
                    dotC <= 16'h0000;
                end
            endcase
            busy        <= (state_r == CLEAR);
            frame_start <= (state_r != CLEAR) && (tick_s == '0) && (row_r == 3'd0);

            if (clr_all) begin
                state_r   <= CLEAR;
                clr_row_r <= 3'd0;
            end else begin
                case (state_r)
                    SCAN_BLANK: begin
                        if (tick_wrap_s) begin
                            state_r <= SCAN_BLANK;
                        end else if (tick_s == TW'(BLANK - 1)) begin
                            state_r <= SCAN_ON;
                        end else begin
                            state_r <= SCAN_BLANK;
                        end
                    end
                    SCAN_ON: begin
                        if (tick_wrap_s) begin
                            state_r <= SCAN_BLANK;
                        end else begin
                            state_r <= SCAN_ON;
                        end
                    end
                    CLEAR: begin
                        if (clr_row_r == 3'd7) begin
                            state_r   <= SCAN_BLANK;
                            clr_row_r <= 3'd0;
                        end else begin
                            clr_row_r <= clr_row_r + 3'd1;
                        end
                    end
                    default: begin
                        state_r   <= SCAN_BLANK;
                        clr_row_r <= 3'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dot_scan_ctrl.sv
// Self-checking bench for dot_scan_ctrl with a frame-phase model of the
// display and directed literal checks on scan order, writes, marks, clear
// collisions and reset during clear.
module tb_dot_scan_ctrl;

    localparam int TD    = 16;
    localparam int BL    = 2;
    localparam int BD    = 64;
    localparam int FRAME = TD * 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        wr_valid;
    logic        wr_ready;
    logic [2:0]  wr_row;
    logic [3:0]  wr_col;
    logic [1:0]  wr_op;
    logic        clr_all;
    logic [7:0]  dotR;
    logic [15:0] dotC;
    logic        frame_start;
    logic        busy;

    dot_scan_ctrl #(.TICK_DIV(TD), .BLANK(BL), .BLINK_DIV(BD)) dut (
        .clock       (clock),
        .reset       (reset),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_row      (wr_row),
        .wr_col      (wr_col),
        .wr_op       (wr_op),
        .clr_all     (clr_all),
        .dotR        (dotR),
        .dotC        (dotC),
        .frame_start (frame_start),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int acc_cnt  = 0;
    int acc_last = 0;

    // Model: cells, phase within the frame, clear cycles left, edges since reset.
    logic [15:0] m_pos  [8];
    logic [15:0] m_mark [8];
    int          m_phase;
    int          m_clr_left;
    int          m_edges;
    logic [7:0]  e_r;
    logic [15:0] e_c;
    logic        e_fs;
    logic        e_busy;
    bit          pend = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, expv);
        end
    endtask

    // Model step: expected outputs reflect the board state before this edge.
    always @(posedge clock) begin : model_p
        int   row;
        int   tk;
        logic blink;
        logic exp_ready;
        if (reset) begin
            for (int r = 0; r < 8; r++) begin
                m_pos[r]  = 16'h0000;
                m_mark[r] = 16'h0000;
            end
            m_phase    = 0;
            m_clr_left = 0;
            m_edges    = 0;
            cyc        = 0;
            pend       = 1'b0;
        end else begin
            blink     = ((m_edges / BD) % 2) == 1;
            exp_ready = (m_clr_left == 0) && !clr_all;
            chk("wr_ready", {31'd0, wr_ready}, {31'd0, exp_ready});
            if (m_clr_left > 0) begin
                e_busy = 1'b1;
                e_fs   = 1'b0;
                e_r    = 8'hFF;
                e_c    = 16'h0000;
            end else begin
                row    = m_phase / TD;
                tk     = m_phase % TD;
                e_busy = 1'b0;
                e_fs   = (m_phase == 0);
                if (tk < BL) begin
                    e_r = 8'hFF;
                    e_c = 16'h0000;
                end else begin
                    e_r = 8'hFF ^ (8'h01 << (7 - row));
                    e_c = m_pos[row] | (blink ? m_mark[row] : 16'h0000);
                end
            end
            if (wr_valid && exp_ready) begin
                case (wr_op)
                    2'b00: m_pos[wr_row][wr_col] = 1'b0;
                    2'b01: begin
                        m_pos[wr_row][wr_col]  = 1'b1;
                        m_mark[wr_row][wr_col] = 1'b0;
                    end
                    2'b10: if (!m_pos[wr_row][wr_col]) m_mark[wr_row][wr_col] = 1'b1;
                    default: m_mark[wr_row][wr_col] = 1'b0;
                endcase
                acc_cnt++;
                acc_last = cyc + 1;
            end
            if (clr_all) begin
                m_clr_left = 8;
                m_phase    = 0;
            end else if (m_clr_left > 0) begin
                m_pos[8 - m_clr_left]  = 16'h0000;
                m_mark[8 - m_clr_left] = 16'h0000;
                m_clr_left--;
                m_phase = 0;
            end else begin
                m_phase = (m_phase + 1) % FRAME;
            end
            m_edges++;
            cyc++;
            pend = 1'b1;
        end
    end

    // Compare registered outputs on the falling edge against the model.
    always @(negedge clock) begin
        if (pend && !reset) begin
            chk("dotR", {24'd0, dotR}, {24'd0, e_r});
            chk("dotC", {16'd0, dotC}, {16'd0, e_c});
            chk("frame_start", {31'd0, frame_start}, {31'd0, e_fs});
            chk("busy", {31'd0, busy}, {31'd0, e_busy});
        end
    end

    task automatic wait_cyc(input int n);
        int guard = 0;
        while (cyc < n && guard < 5000) begin
            @(negedge clock);
            guard++;
        end
        chk("cycle_reached", cyc, n);
    endtask

    task automatic write_one(input logic [2:0] r, input logic [3:0] c, input logic [1:0] op);
        wr_valid = 1'b1;
        wr_row   = r;
        wr_col   = c;
        wr_op    = op;
        #1;
        chk("wr_ready_idle", {31'd0, wr_ready}, 32'd1);
        @(negedge clock);
    endtask

    task automatic check_reset_values();
        chk("rst_dotR", {24'd0, dotR}, 32'h0000_00FF);
        chk("rst_dotC", {16'd0, dotC}, 32'd0);
        chk("rst_frame_start", {31'd0, frame_start}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
    endtask

    initial begin
        int n0;
        reset    = 1'b1;
        wr_valid = 1'b0;
        clr_all  = 1'b0;
        wr_row   = 3'd0;
        wr_col   = 4'd0;
        wr_op    = 2'b00;
        #12;
        check_reset_values();
        @(negedge clock);
        reset = 1'b0;

        // Scan order and frame pulse.
        wait_cyc(1);
        chk("lit_fs_first", {31'd0, frame_start}, 32'd1);
        chk("lit_blank_first", {24'd0, dotR}, 32'h0000_00FF);
        wait_cyc(3);
        chk("lit_row0", {24'd0, dotR}, 32'h0000_007F);
        wait_cyc(19);
        chk("lit_row1", {24'd0, dotR}, 32'h0000_00BF);
        wait_cyc(127);
        chk("lit_row7", {24'd0, dotR}, 32'h0000_00FE);
        wait_cyc(129);
        chk("lit_fs_frame2", {31'd0, frame_start}, 32'd1);

        // Position at row 3 col 5, mark at row 0 col 0.
        write_one(3'd3, 4'd5, 2'b01);
        write_one(3'd0, 4'd0, 2'b10);
        wr_valid = 1'b0;
        wait_cyc(180);
        chk("lit_row3_sel", {24'd0, dotR}, 32'h0000_00EF);
        chk("lit_row3_pos", {16'd0, dotC}, 32'h0000_0020);
        wait_cyc(260);
        chk("lit_mark_hidden", {16'd0, dotC}, 32'h0000_0000);

        // Write colliding with clear: clear wins, write held until done.
        wait_cyc(310);
        wr_valid = 1'b1;
        wr_row   = 3'd0;
        wr_col   = 4'd0;
        wr_op    = 2'b10;
        clr_all  = 1'b1;
        #1;
        chk("lit_ready_collide", {31'd0, wr_ready}, 32'd0);
        n0 = acc_cnt;
        @(negedge clock);
        clr_all = 1'b0;
        wait_cyc(312);
        chk("lit_busy_first", {31'd0, busy}, 32'd1);
        wait_cyc(319);
        chk("lit_busy_last", {31'd0, busy}, 32'd1);
        chk("lit_clear_dark", {16'd0, dotC}, 32'd0);
        while (acc_cnt == n0 && cyc < 340) @(negedge clock);
        chk("held_write_edge", acc_last, 320);
        wr_valid = 1'b0;
        chk("lit_busy_done", {31'd0, busy}, 32'd0);
        chk("lit_fs_after_clear", {31'd0, frame_start}, 32'd1);
        wait_cyc(323);
        chk("lit_mark_shown_sel", {24'd0, dotR}, 32'h0000_007F);
        chk("lit_mark_shown", {16'd0, dotC}, 32'h0000_0001);
        wait_cyc(372);
        chk("lit_row3_cleared", {16'd0, dotC}, 32'h0000_0000);

        // Mark request on a cell holding a position is ignored.
        wait_cyc(390);
        write_one(3'd3, 4'd5, 2'b01);
        write_one(3'd3, 4'd5, 2'b10);
        wr_valid = 1'b0;
        wait_cyc(500);
        chk("lit_row3_pos_again", {16'd0, dotC}, 32'h0000_0020);
        wait_cyc(512);
        write_one(3'd3, 4'd5, 2'b00);
        wr_valid = 1'b0;
        wait_cyc(580);
        chk("lit_row0_mark_blink", {16'd0, dotC}, 32'h0000_0001);
        wait_cyc(628);
        chk("lit_no_mark_on_pos", {16'd0, dotC}, 32'h0000_0000);

        // Reset in the fourth clear cycle.
        wait_cyc(640);
        write_one(3'd7, 4'd15, 2'b01);
        wr_valid = 1'b0;
        wait_cyc(692);
        chk("lit_row7_sel", {24'd0, dotR}, 32'h0000_00FE);
        chk("lit_row7_pos", {16'd0, dotC}, 32'h0000_8000);
        wait_cyc(700);
        clr_all = 1'b1;
        @(negedge clock);
        clr_all = 1'b0;
        wait_cyc(703);
        chk("lit_busy_mid", {31'd0, busy}, 32'd1);
        wait_cyc(704);
        #3;
        reset = 1'b1;
        #1;
        check_reset_values();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        wait_cyc(1);
        chk("lit_fs_rerun", {31'd0, frame_start}, 32'd1);
        wait_cyc(3);
        chk("lit_row0_empty", {16'd0, dotC}, 32'h0000_0000);
        wait_cyc(117);
        chk("lit_row7_sel_rerun", {24'd0, dotR}, 32'h0000_00FE);
        chk("lit_row7_empty", {16'd0, dotC}, 32'h0000_0000);
        wait_cyc(130);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dot_scan_ctrl.md
DOT_SCAN_CTRL -- requirements
Module: dot_scan_ctrl

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 2500: clocks per row period.
REQ-002 The block SHALL have parameter BLANK, default 8: clocks at row-period start with all rows off; legal range 1..TICK_DIV-1.
REQ-003 The block SHALL have parameter BLINK_DIV, default 12500000: clocks per blink half-period.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have ports wr_valid (input, 1 bit) and wr_ready (output, 1 bit): cell-write handshake.
REQ-007 The block SHALL have ports wr_row (input, 3 bits), wr_col (input, 4 bits) and wr_op (input, 2 bits): target cell and operation.
REQ-008 The block SHALL have port clr_all, input, 1 bit: clear-whole-board request, sampled every cycle.
REQ-009 The block SHALL have port dotR, output, 8 bits: active-low row select.
REQ-010 The block SHALL have port dotC, output, 16 bits: active-high column data.
REQ-011 The block SHALL have ports frame_start (output, 1 bit, one-cycle pulse) and busy (output, 1 bit, high while clearing).

Function
REQ-012 The block SHALL hold an 8x16 pos buffer and an 8x16 mark buffer.
REQ-013 wr_op SHALL decode as follows:
- 00 clear pos.
- 01 set pos and clear mark.
- 10 set mark; no-op if pos is already set.
- 11 clear mark.
REQ-014 A write SHALL be accepted on a cycle with wr_valid=1 and wr_ready=1, and the buffer SHALL update at that clock edge.
REQ-015 wr_ready SHALL be 0 while in CLEAR or when clr_all=1; otherwise it SHALL be 1.
REQ-016 A write SHALL NOT be accepted in the same cycle as clr_all; clr_all wins, and the requester SHALL hold wr_valid.
REQ-017 The FSM SHALL have states SCAN_BLANK, SCAN_ON and CLEAR.
REQ-018 A tick counter SHALL count 0..TICK_DIV-1 and wrap.
- The row counter SHALL count 0..7 and increment on tick wrap.
- Row 7 SHALL wrap to row 0.
REQ-019 SCAN_BLANK SHALL last while tick<BLANK, and SCAN_ON SHALL last for the rest of the row period; the FSM SHALL return to SCAN_BLANK at tick wrap.
REQ-020 In SCAN_BLANK, dotR SHALL be 8'hFF and dotC SHALL be 0.
REQ-021 In SCAN_ON, dotR SHALL drive bit (7-row) low only (row 0 -> 8'b01111111, row 7 -> 8'b11111110).
REQ-022 In SCAN_ON, dotC SHALL be pos[row] OR (blink ? mark[row] : 0).
REQ-023 dotR and dotC SHALL be registered, so a write accepted at edge N SHALL be visible on dotC after edge N+1.
REQ-024 frame_start SHALL pulse for one cycle when row=0 and tick=0.
REQ-025 blink SHALL be a free-running toggle every BLINK_DIV clocks, independent of FSM state.
REQ-026 clr_all=1 in any state SHALL take the FSM to CLEAR.
- CLEAR SHALL zero one row of both buffers per cycle, row 0 first, over 8 cycles.
- busy SHALL be 1, dotR SHALL be 8'hFF and dotC SHALL be 0 throughout CLEAR.
REQ-027 On leaving CLEAR, tick and row SHALL be 0 and the state SHALL be SCAN_BLANK, with frame_start pulsing.
REQ-028 clr_all asserted during CLEAR SHALL restart the clear at row 0.

Reset
REQ-029 On reset assertion, asynchronously:
- dotR SHALL be 8'hFF and dotC, frame_start and busy SHALL be 0.
- wr_ready SHALL be 0.
- Both buffers, tick, row and blink SHALL be 0.
- The state SHALL be SCAN_BLANK.
REQ-030 In the first cycle after reset deassertion, wr_ready SHALL be 1 and scanning SHALL begin at row 0, tick 0 with a frame_start pulse.
REQ-031 Reset mid-CLEAR or mid-write SHALL discard the operation with no partial state retained.

Structure
REQ-032 The shared package dot_pkg SHALL hold the following:
- ROWS=8 and COLS=16.
- wr_op encodings OP_CLR_POS, OP_SET_POS, OP_SET_MARK and OP_CLR_MARK.
- The FSM state enum.
REQ-033 One sub-module, tick_gen (parameterised divider, wrap pulse output), SHALL be instantiated twice: for the row tick and for blink.

Verification
Bench parameters: TICK_DIV=16, BLANK=2, BLINK_DIV=64.
REQ-034 Scan order: reset, idle for 128 clocks -> dotR cycles 7F,BF,...,FE, each low for 14 clocks after 2 clocks of FF; frame_start every 128 clocks.
REQ-035 Write: op 01 at row 3, col 5 -> wr_ready=1 and the write is accepted; in row-3 SCAN_ON, dotC=16'h0020 regardless of blink.
REQ-036 Mark: op 10 at row 0, col 0 -> dotC in row 0 alternates 0001/0000 every 64 clocks; then op 10 at row 3, col 5 (pos already set) -> no mark change.
REQ-037 Collision: wr_valid and clr_all in the same cycle -> write not accepted, busy=1 for 8 cycles, all dotC=0 afterwards, then the held write is accepted.
REQ-038 Reset mid-CLEAR: reset asserted in CLEAR cycle 4 -> all outputs at reset values immediately; buffers read all zero after release.
